// File: rtl/rv_stage_ex.sv
`default_nettype none
// rv_stage_ex: RV32I execute stage. It handles operand forwarding, the ALU, branch/jump
// resolution with a combinational redirect, and the EX/MEM pipeline register. Revision 1.0
module rv_stage_ex #(
  parameter int XLEN = 32
) (
  input  logic            i_ex_clk,
  input  logic            i_ex_rst,
  input  logic            i_ex_bubble,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_rs1_rdata,
  input  logic [XLEN-1:0] i_ex_rs2_rdata,
  input  logic [XLEN-1:0] i_ex_ext_imm,
  input  logic [1:0]      i_ex_rs1_fwd_sel,
  input  logic [1:0]      i_ex_rs2_fwd_sel,
  input  logic [XLEN-1:0] i_ex_fwd_mem_data,
  input  logic [XLEN-1:0] i_ex_fwd_wb_data,
  input  logic [3:0]      i_ex_alu_op,
  input  logic            i_ex_alu_a_pc,
  input  logic            i_ex_alu_b_imm,
  input  logic            i_ex_is_branch,
  input  logic            i_ex_is_jal,
  input  logic            i_ex_is_jalr,
  input  logic [2:0]      i_ex_func3,
  input  logic            i_ex_is_load,
  input  logic            i_ex_dmem_wen,
  input  logic            i_ex_rf_wen,
  input  logic [4:0]      i_ex_rf_waddr,
  input  logic [1:0]      i_ex_rf_wdata_pre_sel,
  output logic            o_ex_redirect,
  output logic [XLEN-1:0] o_ex_redirect_pc,
  output logic            o_ex_mem_is_load,
  output logic [2:0]      o_ex_mem_func3,
  output logic [XLEN-1:0] o_ex_mem_alu_res,
  output logic [XLEN-1:0] o_ex_mem_ext_imm,
  output logic [XLEN-1:0] o_ex_mem_pc_plus_4,
  output logic            o_ex_mem_dmem_wen,
  output logic [XLEN-1:0] o_ex_mem_dmem_wdata,
  output logic            o_ex_mem_rf_wen,
  output logic [4:0]      o_ex_mem_rf_waddr,
  output logic [1:0]      o_ex_mem_rf_wdata_pre_sel
);
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, alu_a, alu_b, alu_res;
  logic [XLEN-1:0] jalr_sum, target;
  logic [4:0]      shamt;
  logic            cond;

  always_comb begin
    case (i_ex_rs1_fwd_sel)
      2'd1:    rs1_fwd = i_ex_fwd_mem_data;
      2'd2:    rs1_fwd = i_ex_fwd_wb_data;
      default: rs1_fwd = i_ex_rs1_rdata;
    endcase
    case (i_ex_rs2_fwd_sel)
      2'd1:    rs2_fwd = i_ex_fwd_mem_data;
      2'd2:    rs2_fwd = i_ex_fwd_wb_data;
      default: rs2_fwd = i_ex_rs2_rdata;
    endcase
  end

  assign alu_a = i_ex_alu_a_pc  ? i_ex_pc      : rs1_fwd;
  assign alu_b = i_ex_alu_b_imm ? i_ex_ext_imm : rs2_fwd;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = '0;
    case (i_ex_alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      default:  alu_res = '0;
    endcase
  end

  // Branch comparison always uses forwarded registers, never the ALU operand muxes.
  always_comb begin
    cond = 1'b0;
    case (i_ex_func3)
      3'b000:  cond = (rs1_fwd == rs2_fwd);
      3'b001:  cond = (rs1_fwd != rs2_fwd);
      3'b100:  cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      3'b101:  cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      3'b110:  cond = (rs1_fwd <  rs2_fwd);
      3'b111:  cond = (rs1_fwd >= rs2_fwd);
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_fwd + i_ex_ext_imm;
  assign target   = i_ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_ex_pc + i_ex_ext_imm);

  assign o_ex_redirect    = !i_ex_bubble & (i_ex_is_jal | i_ex_is_jalr | (i_ex_is_branch & cond));
  assign o_ex_redirect_pc = target;

  always_ff @(posedge i_ex_clk) begin
    if (i_ex_rst) begin
      o_ex_mem_is_load          <= 1'b0;
      o_ex_mem_func3            <= '0;
      o_ex_mem_alu_res          <= '0;
      o_ex_mem_ext_imm          <= '0;
      o_ex_mem_pc_plus_4        <= '0;
      o_ex_mem_dmem_wen         <= 1'b0;
      o_ex_mem_dmem_wdata       <= '0;
      o_ex_mem_rf_wen           <= 1'b0;
      o_ex_mem_rf_waddr         <= '0;
      o_ex_mem_rf_wdata_pre_sel <= '0;
    end else begin
      o_ex_mem_is_load          <= i_ex_is_load  & !i_ex_bubble;
      o_ex_mem_dmem_wen         <= i_ex_dmem_wen & !i_ex_bubble;
      o_ex_mem_rf_wen           <= i_ex_rf_wen   & !i_ex_bubble;
      o_ex_mem_func3            <= i_ex_func3;
      o_ex_mem_alu_res          <= alu_res;
      o_ex_mem_ext_imm          <= i_ex_ext_imm;
      o_ex_mem_pc_plus_4        <= i_ex_pc + XLEN'(4);
      o_ex_mem_dmem_wdata       <= rs2_fwd;
      o_ex_mem_rf_waddr         <= i_ex_rf_waddr;
      o_ex_mem_rf_wdata_pre_sel <= i_ex_rf_wdata_pre_sel;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rv_stage_ex.sv
`default_nettype none
// tb_rv_stage_ex: directed vector table plus randomized checks against a behavioural model.
module tb_rv_stage_ex;
  logic        clk = 1'b0;
  logic        rst, bubble;
  logic [31:0] pc, rs1, rs2, imm, fwd_mem, fwd_wb;
  logic [1:0]  s1, s2, pre_sel;
  logic [3:0]  op;
  logic        apc, bimm, br, jal, jalr, is_load, dwen, rfwen;
  logic [2:0]  f3;
  logic [4:0]  waddr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        m_is_load, m_dwen, m_rfwen;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_imm, m_pc4, m_wdata;
  logic [4:0]  m_waddr;
  logic [1:0]  m_pre;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rv_stage_ex #(.XLEN(32)) dut (
    .i_ex_clk(clk), .i_ex_rst(rst), .i_ex_bubble(bubble), .i_ex_pc(pc),
    .i_ex_rs1_rdata(rs1), .i_ex_rs2_rdata(rs2), .i_ex_ext_imm(imm),
    .i_ex_rs1_fwd_sel(s1), .i_ex_rs2_fwd_sel(s2),
    .i_ex_fwd_mem_data(fwd_mem), .i_ex_fwd_wb_data(fwd_wb),
    .i_ex_alu_op(op), .i_ex_alu_a_pc(apc), .i_ex_alu_b_imm(bimm),
    .i_ex_is_branch(br), .i_ex_is_jal(jal), .i_ex_is_jalr(jalr), .i_ex_func3(f3),
    .i_ex_is_load(is_load), .i_ex_dmem_wen(dwen), .i_ex_rf_wen(rfwen),
    .i_ex_rf_waddr(waddr), .i_ex_rf_wdata_pre_sel(pre_sel),
    .o_ex_redirect(redirect), .o_ex_redirect_pc(redirect_pc),
    .o_ex_mem_is_load(m_is_load), .o_ex_mem_func3(m_f3), .o_ex_mem_alu_res(m_alu),
    .o_ex_mem_ext_imm(m_imm), .o_ex_mem_pc_plus_4(m_pc4), .o_ex_mem_dmem_wen(m_dwen),
    .o_ex_mem_dmem_wdata(m_wdata), .o_ex_mem_rf_wen(m_rfwen), .o_ex_mem_rf_waddr(m_waddr),
    .o_ex_mem_rf_wdata_pre_sel(m_pre)
  );

  typedef struct {
    string       nm;
    logic [1:0]  s1;
    logic [31:0] pc, rs1, rs2, imm;
    logic [3:0]  op;
    logic        apc, bimm, br, jal, jalr;
    logic [2:0]  f3;
    logic        bub;
    logic [31:0] e_alu;
    logic        e_red;
    logic [31:0] e_rpc;
  } vec_t;

  function automatic vec_t mk(string nm, logic [1:0] s1_, logic [31:0] pc_, logic [31:0] rs1_,
                              logic [31:0] rs2_, logic [31:0] imm_, logic [3:0] op_, logic apc_,
                              logic bimm_, logic br_, logic jal_, logic jalr_, logic [2:0] f3_,
                              logic bub_, logic [31:0] e_alu_, logic e_red_, logic [31:0] e_rpc_);
    vec_t v;
    v.nm = nm; v.s1 = s1_; v.pc = pc_; v.rs1 = rs1_; v.rs2 = rs2_; v.imm = imm_; v.op = op_;
    v.apc = apc_; v.bimm = bimm_; v.br = br_; v.jal = jal_; v.jalr = jalr_; v.f3 = f3_;
    v.bub = bub_; v.e_alu = e_alu_; v.e_red = e_red_; v.e_rpc = e_rpc_;
    return v;
  endfunction

  // Reference model, written directly from the instruction-set semantics.
  function automatic logic [31:0] m_fwd(logic [1:0] sel, logic [31:0] rf, logic [31:0] mem,
                                        logic [31:0] wb);
    return (sel == 2'd1) ? mem : (sel == 2'd2) ? wb : rf;
  endfunction

  function automatic logic [31:0] m_alu_f(logic [3:0] o, logic [31:0] a, logic [31:0] b);
    int sh = int'(b % 32);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return (sa < sb) ? 32'd1 : 32'd0;
      4'd4: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_cond(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (f)
      3'b000: return ua == ub;
      3'b001: return ua != ub;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return ua < ub;
      3'b111: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    bubble = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0; fwd_mem = 0; fwd_wb = 0;
    s1 = 0; s2 = 0; pre_sel = 0; op = 0; apc = 0; bimm = 0; br = 0; jal = 0; jalr = 0;
    is_load = 0; dwen = 0; rfwen = 0; f3 = 0; waddr = 0;
  endtask

  task automatic check_regs(input string nm, input logic [31:0] e_alu, input logic [31:0] e_imm,
                            input logic [31:0] e_pc4, input logic [31:0] e_wd, input logic [2:0] e_f3,
                            input logic [4:0] e_wa, input logic [1:0] e_pre, input logic e_ld,
                            input logic e_dw, input logic e_rw);
    chk({nm, ".alu_res"}, m_alu, e_alu);
    chk({nm, ".ext_imm"}, m_imm, e_imm);
    chk({nm, ".pc4"}, m_pc4, e_pc4);
    chk({nm, ".wdata"}, m_wdata, e_wd);
    chk({nm, ".func3"}, 32'(m_f3), 32'(e_f3));
    chk({nm, ".waddr"}, 32'(m_waddr), 32'(e_wa));
    chk({nm, ".pre_sel"}, 32'(m_pre), 32'(e_pre));
    chk({nm, ".is_load"}, 32'(m_is_load), 32'(e_ld));
    chk({nm, ".dmem_wen"}, 32'(m_dwen), 32'(e_dw));
    chk({nm, ".rf_wen"}, 32'(m_rfwen), 32'(e_rw));
  endtask

  vec_t vt[$];

  initial begin
    set_idle();
    rst = 1;
    vt.push_back(mk("fwd_mem", 2'd1, 32'h0, 32'd1, 32'd2, 32'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, 32'd7, 0, 32'h0));
    vt.push_back(mk("fwd_wb",  2'd2, 32'h0, 32'd1, 32'd2, 32'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, 32'd11, 0, 32'h0));
    vt.push_back(mk("fwd_rf3", 2'd3, 32'h0, 32'd1, 32'd2, 32'd0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, 32'd3, 0, 32'h0));
    vt.push_back(mk("sra", 2'd0, 32'h0, 32'h8000_0000, 32'd0, 32'd4, 4'd7, 0, 1, 0, 0, 0, 3'd0, 0, 32'hF800_0000, 0, 32'h4));
    vt.push_back(mk("slt", 2'd0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd3, 0, 0, 0, 0, 0, 3'd0, 0, 32'd1, 0, 32'h0));
    vt.push_back(mk("sltu", 2'd0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd4, 0, 0, 0, 0, 0, 3'd0, 0, 32'd0, 0, 32'h0));
    vt.push_back(mk("sub", 2'd0, 32'h0, 32'd0, 32'd1, 32'd0, 4'd1, 0, 0, 0, 0, 0, 3'd0, 0, 32'hFFFF_FFFF, 0, 32'h0));
    vt.push_back(mk("sll_b5", 2'd0, 32'h0, 32'd1, 32'h21, 32'd0, 4'd2, 0, 0, 0, 0, 0, 3'd0, 0, 32'd2, 0, 32'h0));
    vt.push_back(mk("blt", 2'd0, 32'h100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 4'd0, 0, 0, 1, 0, 0, 3'b100, 0, 32'hFFFF_FFFF, 1, 32'hF8));
    vt.push_back(mk("bltu", 2'd0, 32'h100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 4'd0, 0, 0, 1, 0, 0, 3'b110, 0, 32'hFFFF_FFFF, 0, 32'hF8));
    vt.push_back(mk("jalr", 2'd0, 32'h40, 32'h203, 32'd0, 32'h10, 4'd0, 0, 1, 0, 0, 1, 3'd0, 0, 32'h213, 1, 32'h212));
    vt.push_back(mk("jal", 2'd0, 32'h40, 32'd0, 32'd0, 32'h20, 4'd0, 1, 1, 0, 1, 0, 3'd0, 0, 32'h60, 1, 32'h60));
    vt.push_back(mk("beq_bub", 2'd0, 32'h200, 32'd5, 32'd5, 32'd8, 4'd0, 0, 0, 1, 0, 0, 3'b000, 1, 32'hA, 0, 32'h208));
    vt.push_back(mk("br_010", 2'd0, 32'h200, 32'd5, 32'd5, 32'd8, 4'd0, 0, 0, 1, 0, 0, 3'b010, 0, 32'hA, 0, 32'h208));

    // Reset held two edges with a valid store and a jump presented.
    pc = 32'h80; rs1 = 32'h11; rs2 = 32'h22; imm = 32'h4; op = 4'd0; bimm = 1;
    dwen = 1; rfwen = 1; is_load = 0; f3 = 3'b010; waddr = 5'd7; pre_sel = 2'd2; jal = 1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check_regs($sformatf("reset%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset.redirect", 32'(redirect), 32'd1);
    end
    rst = 0;
    @(posedge clk); #1;
    check_regs("post_reset", 32'h15, 32'h4, 32'h84, 32'h22, 3'b010, 5'd7, 2'd2, 0, 1, 1);

    // Directed table.
    foreach (vt[i]) begin
      set_idle();
      s1 = vt[i].s1; pc = vt[i].pc; rs1 = vt[i].rs1; rs2 = vt[i].rs2; imm = vt[i].imm;
      op = vt[i].op; apc = vt[i].apc; bimm = vt[i].bimm; br = vt[i].br; jal = vt[i].jal;
      jalr = vt[i].jalr; f3 = vt[i].f3; bubble = vt[i].bub; fwd_mem = 32'd5; fwd_wb = 32'd9;
      is_load = 1; dwen = 1; rfwen = 1; waddr = 5'(i); pre_sel = 2'(i);
      #1;
      chk({vt[i].nm, ".redirect"}, 32'(redirect), 32'(vt[i].e_red));
      chk({vt[i].nm, ".redirect_pc"}, redirect_pc, vt[i].e_rpc);
      @(posedge clk); #1;
      check_regs(vt[i].nm, vt[i].e_alu, vt[i].imm, vt[i].pc + 32'd4, vt[i].rs2, vt[i].f3,
                 5'(i), 2'(i), !vt[i].bub, !vt[i].bub, !vt[i].bub);
    end

    // x0 destination with rf_wen passes through untouched.
    set_idle(); rfwen = 1; waddr = 5'd0;
    @(posedge clk); #1;
    chk("x0.rf_wen", 32'(m_rfwen), 32'd1);

    // Reset wins over a bubble and over live control.
    set_idle(); rst = 1; bubble = 1; dwen = 1; rfwen = 1; is_load = 1; pc = 32'h10;
    @(posedge clk); #1;
    check_regs("rst_bub", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 0;

    // Randomized against the model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b, r1f, r2f, tgt;
      logic        e_red;
      int          cls;
      set_idle();
      pc = $urandom; rs1 = $urandom; rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      imm = $urandom; fwd_mem = $urandom; fwd_wb = $urandom;
      s1 = 2'($urandom); s2 = 2'($urandom); op = 4'($urandom_range(0, 9));
      apc = 1'($urandom); bimm = 1'($urandom); f3 = 3'($urandom); bubble = ($urandom_range(0, 4) == 0);
      is_load = 1'($urandom); dwen = 1'($urandom); rfwen = 1'($urandom);
      waddr = 5'($urandom); pre_sel = 2'($urandom);
      cls = $urandom_range(0, 3);
      br = (cls == 1); jal = (cls == 2); jalr = (cls == 3);
      r1f = m_fwd(s1, rs1, fwd_mem, fwd_wb);
      r2f = m_fwd(s2, rs2, fwd_mem, fwd_wb);
      a = apc ? pc : r1f;
      b = bimm ? imm : r2f;
      tgt = jalr ? ((r1f + imm) & 32'hFFFF_FFFE) : (pc + imm);
      e_red = !bubble && (jal || jalr || (br && m_cond(f3, r1f, r2f)));
      #1;
      chk("rnd.redirect", 32'(redirect), 32'(e_red));
      chk("rnd.redirect_pc", redirect_pc, tgt);
      @(posedge clk); #1;
      check_regs("rnd", m_alu_f(op, a, b), imm, pc + 32'd4, r2f, f3, waddr, pre_sel,
                 is_load && !bubble, dwen && !bubble, rfwen && !bubble);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
